icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_ram.sv | 70 +++++++
 rtl/icache_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_icache_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the instruction-cache controller.
//   - default geometry (lines, words per line, address width)
//   - FSM state encoding
//   - field-width constants for address decoding and the miss counter
//   - saturating counter increment helper
package icache_pkg;

    localparam int LINES_DEF  = 8;
    localparam int WORDS_DEF  = 4;
    localparam int ADDR_W_DEF = 64;

    localparam int INSTR_W    = 32;   // instruction / memory word width
    localparam int CNT_W      = 16;   // miss counter width
    localparam int BYTE_OFF_W = 2;    // byte-within-word bits, ignored by the cache

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/icache_ram.sv
// icache_ram: storage for a direct-mapped instruction cache.
//   Holds a valid bit, a tag and WORDS data words per line.
//   Ports:
//     clk, rst_n           clock, async active-low reset (clears valid bits only)
//     rd_index, rd_offset  combinational read address (line, word in line)
//     rd_valid, rd_tag     valid bit and tag of line rd_index
//     rd_data              data word at (rd_index, rd_offset)
//     wr_index             line targeted by every write-side operation
//     wr_offset, wr_data   data word write address / value
//     data_we              write wr_data into the data array
//     tag_we, wr_tag       write wr_tag into the tag array
//     set_line             mark line wr_index valid
//     inv_line             mark line wr_index invalid
//     clr_all              clear every valid bit (highest priority)
module icache_ram
    import icache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int TAG_W = 57
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(LINES)-1:0]   rd_index,
    input  logic [$clog2(WORDS)-1:0]   rd_offset,
    output logic                       rd_valid,
    output logic [TAG_W-1:0]           rd_tag,
    output logic [INSTR_W-1:0]         rd_data,
    input  logic [$clog2(LINES)-1:0]   wr_index,
    input  logic [$clog2(WORDS)-1:0]   wr_offset,
    input  logic [INSTR_W-1:0]         wr_data,
    input  logic                       data_we,
    input  logic                       tag_we,
    input  logic [TAG_W-1:0]           wr_tag,
    input  logic                       set_line,
    input  logic                       inv_line,
    input  logic                       clr_all
);

    logic [INSTR_W-1:0] data_mem [LINES*WORDS];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid;

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

    // Data and tags carry no reset; a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else if (inv_line) begin
            valid[wr_index] <= 1'b0;
        end else if (set_line) begin
            valid[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, blocking instruction cache controller.
//   Hits return in the same cycle; a miss fills the whole line from backing
//   memory one word at a time, then the lookup is repeated.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     cpu_req, cpu_addr     fetch request and byte address
//     cpu_ready, cpu_instr  fetch result valid / instruction
//     flush                 invalidate all lines (fence.i)
//     mem_req, mem_addr     backing memory read request / word-aligned address
//     mem_rdata, mem_valid  backing memory read data / completion
//     miss_count            saturating count of line fills started
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic                cpu_ready,
    output logic [INSTR_W-1:0]  cpu_instr,
    input  logic                flush,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [INSTR_W-1:0]  mem_rdata,
    input  logic                mem_valid,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = ADDR_W - BYTE_OFF_W - OFF_W;   // line address width
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    state_t state, next_state;

    // Address fields of the current request
    logic [LINE_W-1:0] cur_line;
    logic [OFF_W-1:0]  cur_offset;
    logic [IDX_W-1:0]  cur_index;
    logic [TAG_W-1:0]  cur_tag;
    logic              unused_addr;

    assign cur_line    = cpu_addr[ADDR_W-1:BYTE_OFF_W+OFF_W];
    assign cur_offset  = cpu_addr[BYTE_OFF_W+OFF_W-1:BYTE_OFF_W];
    assign cur_index   = cur_line[IDX_W-1:0];
    assign cur_tag     = cur_line[LINE_W-1:IDX_W];
    assign unused_addr = ^cpu_addr[BYTE_OFF_W-1:0];

    // Fill context: latched at the miss so cpu_addr may wander during the fill
    logic [LINE_W-1:0] fill_line;
    logic [OFF_W-1:0]  fill_word;
    logic              flush_pend;

    // RAM interface
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [INSTR_W-1:0] rd_data;
    logic [IDX_W-1:0]   ram_wr_index;
    logic               ram_data_we, ram_tag_we, ram_set, ram_inv, ram_clr;

    logic hit, start_fill, fill_done;

    assign hit        = cpu_req && rd_valid && (rd_tag == cur_tag);
    assign start_fill = (state == IDLE) && cpu_req && !flush && !hit;
    assign fill_done  = (state == FILL) && mem_valid && (fill_word == LAST_WORD);

    icache_ram #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (cur_index),
        .rd_offset (cur_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (ram_wr_index),
        .wr_offset (fill_word),
        .wr_data   (mem_rdata),
        .data_we   (ram_data_we),
        .tag_we    (ram_tag_we),
        .wr_tag    (fill_line[LINE_W-1:IDX_W]),
        .set_line  (ram_set),
        .inv_line  (ram_inv),
        .clr_all   (ram_clr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_fill) next_state = FILL;
            FILL: if (fill_done)  next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_ready    = 1'b0;
        cpu_instr    = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        ram_wr_index = cur_index;
        ram_data_we  = 1'b0;
        ram_tag_we   = 1'b0;
        ram_set      = 1'b0;
        ram_inv      = 1'b0;
        ram_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    ram_clr = 1'b1;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_instr = rd_data;
                end else if (cpu_req) begin
                    // The victim line is dropped up front so a fill that never
                    // finishes cannot leave stale words under a valid tag.
                    ram_inv = 1'b1;
                end
            end
            FILL: begin
                ram_wr_index = fill_line[IDX_W-1:0];
                mem_req      = 1'b1;
                mem_addr     = {fill_line, fill_word, {BYTE_OFF_W{1'b0}}};
                if (mem_valid) begin
                    ram_data_we = 1'b1;
                    if (fill_word == LAST_WORD) begin
                        // A flush seen at any point of the fill, including this
                        // last cycle, discards the new line with everything else.
                        if (flush_pend || flush) begin
                            ram_clr = 1'b1;
                        end else begin
                            ram_tag_we = 1'b1;
                            ram_set    = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Fill control and miss counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_word  <= '0;
            flush_pend <= 1'b0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fill) begin
                        fill_word  <= '0;
                        flush_pend <= 1'b0;
                        miss_count <= sat_inc(miss_count);
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_valid) begin
                        fill_word <= fill_word + 1'b1;
                        if (fill_word == LAST_WORD) begin
                            flush_pend <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Line address of the fill in progress (data path, no reset)
    always_ff @(posedge clk) begin
        if (start_fill) begin
            fill_line <= cur_line;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed self-checking bench for icache_ctrl.
//   Backing memory is a small table; inputs change and outputs are sampled
//   1 ns after the falling clock edge.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [63:0] cpu_addr;
    logic        cpu_ready;
    logic [31:0] cpu_instr;
    logic        flush;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] miss_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    icache_ctrl #(
        .LINES  (8),
        .WORDS  (4),
        .ADDR_W (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_instr  (cpu_instr),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .miss_count (miss_count)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h00:  return 32'h100102b7;
            64'h04:  return 32'h00800313;
            64'h08:  return 32'h00100393;
            64'h0c:  return 32'h0263d663;
            64'h80:  return 32'h00100073;
            default: return 32'h00000013;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a fetch on the next falling edge and check the IDLE response.
    task automatic lookup(input logic [63:0] a, input logic exp_ready,
                          input logic [31:0] exp_instr, input logic fl);
        @(negedge clk);
        mem_valid = 1'b0;
        flush     = fl;
        cpu_req   = 1'b1;
        cpu_addr  = a;
        #1;
        chk("lookup_ready", cpu_ready, exp_ready);
        chk("lookup_mem_req", mem_req, 1'b0);
        if (exp_ready) chk("lookup_instr", cpu_instr, exp_instr);
    endtask

    // Answer nwords requests of a line fill, each after `delay` idle cycles.
    task automatic serve_fill(input logic [63:0] base, input int delay, input int nwords,
                              input int flush_word, input bit scramble);
        for (int k = 0; k < nwords; k++) begin
            for (int d = 0; d <= delay; d++) begin
                @(negedge clk);
                mem_valid = 1'b0;
                flush     = (k == flush_word) && (d == 0);
                if (scramble && k == 0 && d == 0) cpu_addr = 64'h200;
                #1;
                chk("fill_mem_req", mem_req, 1'b1);
                chk("fill_mem_addr", mem_addr, base + 64'(4 * k));
                chk("fill_ready", cpu_ready, 1'b0);
            end
            mem_valid = 1'b1;
            mem_rdata = mem_word(base + 64'(4 * k));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        flush     = 1'b0;
        mem_rdata = '0;
        mem_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", cpu_ready, 1'b0);
        chk("rst_instr", cpu_instr, 32'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_miss", miss_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss at 0x00, line fill, then hit
        lookup(64'h00, 1'b0, 32'h0, 1'b0);
        serve_fill(64'h00, 0, 4, -1, 1'b0);
        lookup(64'h00, 1'b1, 32'h100102b7, 1'b0);
        chk("miss_after_first", miss_count, 16'd1);

        // Same-line hit at 0x08
        lookup(64'h08, 1'b1, 32'h00100393, 1'b0);
        chk("miss_after_hit", miss_count, 16'd1);

        // Index-0 conflict: 0x80 evicts 0x00, then 0x00 evicts 0x80
        lookup(64'h80, 1'b0, 32'h0, 1'b0);
        serve_fill(64'h80, 0, 4, -1, 1'b0);
        lookup(64'h80, 1'b1, 32'h00100073, 1'b0);
        lookup(64'h00, 1'b0, 32'h0, 1'b0);
        serve_fill(64'h00, 0, 4, -1, 1'b0);
        lookup(64'h00, 1'b1, 32'h100102b7, 1'b0);
        chk("miss_after_conflict", miss_count, 16'd3);

        // Slow memory, cpu_addr moved away during the fill
        lookup(64'h40, 1'b0, 32'h0, 1'b0);
        serve_fill(64'h40, 5, 4, -1, 1'b1);
        lookup(64'h40, 1'b1, 32'h00000013, 1'b0);
        chk("miss_after_slow", miss_count, 16'd4);
        lookup(64'h0c, 1'b1, 32'h0263d663, 1'b0);

        // Flush in IDLE blocks the hit and invalidates
        lookup(64'h00, 1'b0, 32'h0, 1'b1);
        chk("miss_flush_idle", miss_count, 16'd4);
        lookup(64'h00, 1'b0, 32'h0, 1'b0);
        chk("miss_after_flush", miss_count, 16'd4);

        // Flush during the fill: line stays invalid, next lookup refills
        serve_fill(64'h00, 0, 4, 1, 1'b0);
        lookup(64'h00, 1'b0, 32'h0, 1'b0);
        chk("miss_flush_fill", miss_count, 16'd5);
        serve_fill(64'h00, 0, 4, -1, 1'b0);
        lookup(64'h00, 1'b1, 32'h100102b7, 1'b0);
        chk("miss_refill", miss_count, 16'd6);

        // Reset after the second word of a fill
        lookup(64'h80, 1'b0, 32'h0, 1'b0);
        serve_fill(64'h80, 0, 2, -1, 1'b0);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("midfill_mem_req", mem_req, 1'b1);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rstfill_mem_req", mem_req, 1'b0);
        chk("rstfill_mem_addr", mem_addr, 64'h0);
        chk("rstfill_ready", cpu_ready, 1'b0);
        chk("rstfill_miss", miss_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup(64'h00, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        chk("post_rst_miss", miss_count, 16'd1);
        chk("post_rst_mem_req", mem_req, 1'b1);
        chk("post_rst_mem_addr", mem_addr, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
